// File: rtl/adc_capture_wb.sv
// rtl/adc_capture_wb.sv - serial ADC frame capture into memory over a Wishbone master (optional test pattern: ADC_CAPTURE_TESTPAT_EN)
module adc_capture_wb #(
    parameter int          NCH      = 4,
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] BASE_ADR = 32'h0
) (
    input  logic              wb_clk_i,
    input  logic              reset_n,
    input  logic              adc_clk,
    input  logic [NCH-1:0]    adc_dat,
    input  logic              enable,
    input  logic              mode,
    input  logic              clr_ovf,
    input  logic              test_en,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_ack_i,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] wr_ptr
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_NEXT, S_FULL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_clk_s1, r_clk_s2, r_clk_s3;
    logic [7:0]        r_dat_s1, r_dat_s2;
    logic              r_en_d;
    logic              r_live;
    logic [4:0]        r_bitcnt;
    logic [31:0]       r_shift [8];
    logic [31:0]       r_hold  [8];
    logic [31:0]       w_shift_nxt [8];
    logic              r_pending;
    logic              r_done;
    logic              r_ovf;
    logic [2:0]        r_chan;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              w_bit_evt, w_frame, w_accept, w_drop_ovf, w_en_rise, w_busy;
    logic              w_last_chan, w_ptr_max;
    logic [31:0]       w_adr_sum;
    logic [31:0]       w_word;

    assign w_bit_evt   = r_clk_s2 & ~r_clk_s3;
    assign w_en_rise   = enable & ~r_en_d;
    assign w_busy      = (r_state == S_WRITE) || (r_state == S_NEXT);
    assign w_frame     = w_bit_evt & enable & (r_bitcnt == 5'd31);
    // Frames arriving while full in one-shot mode are dropped silently.
    assign w_accept    = w_frame & (r_state == S_IDLE) & ~r_pending & ~r_done;
    assign w_drop_ovf  = w_frame & (w_busy | r_pending);
    assign w_last_chan = (r_chan == 3'(NCH - 1));
    assign w_ptr_max   = (r_wr_ptr == {ADDR_W{1'b1}});
    assign w_adr_sum   = BASE_ADR + 32'({r_wr_ptr, 2'b00});

    // Next shift-register contents: new bit enters at the top, first bit ends at bit 0.
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            w_shift_nxt[c] = {r_dat_s2[c], r_shift[c][31:1]};
        end
    end

    // Burst FSM state register; reset drops the bus cycle immediately.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_pending) w_state_nxt = S_WRITE;
            S_WRITE: if (wb_ack_i) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (!mode && w_ptr_max) w_state_nxt = S_FULL;
                else if (w_last_chan)   w_state_nxt = S_IDLE;
                else                    w_state_nxt = S_WRITE;
            end
            S_FULL:  if (w_en_rise) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Synchronisers, deserialisers, frame hand-off, pointers and status flags.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1  <= 1'b0;
            r_clk_s2  <= 1'b0;
            r_clk_s3  <= 1'b0;
            r_dat_s1  <= 8'd0;
            r_dat_s2  <= 8'd0;
            r_en_d    <= 1'b0;
            r_live    <= 1'b0;
            r_bitcnt  <= 5'd0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_chan    <= 3'd0;
            r_wr_ptr  <= '0;
            for (int c = 0; c < 8; c++) begin
                r_shift[c] <= 32'd0;
                r_hold[c]  <= 32'd0;
            end
        end else begin
            r_clk_s1 <= adc_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= 8'(adc_dat);
            r_dat_s2 <= r_dat_s1;
            r_en_d   <= enable;
            r_live   <= 1'b1;

            if (!enable) begin
                r_bitcnt <= 5'd0;
            end else if (w_bit_evt) begin
                r_bitcnt <= r_bitcnt + 5'd1;
                for (int c = 0; c < 8; c++) begin
                    r_shift[c] <= w_shift_nxt[c];
                end
            end

            if (w_accept) begin
                r_pending <= 1'b1;
                for (int c = 0; c < 8; c++) begin
                    r_hold[c] <= w_shift_nxt[c];
                end
            end else if (r_state == S_IDLE && r_pending) begin
                r_pending <= 1'b0;
            end

            if (w_drop_ovf) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end

            if (r_state == S_NEXT) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_chan   <= w_last_chan ? 3'd0 : r_chan + 3'd1;
                if (w_state_nxt == S_FULL) begin
                    r_done <= 1'b1;
                    r_chan <= 3'd0;
                end
            end

            if (w_en_rise) begin
                r_wr_ptr <= '0;
                r_done   <= 1'b0;
                r_chan   <= 3'd0;
            end
        end
    end

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [15:0] r_frm_cnt;
    logic [15:0] r_frm_hold;

    // Accepted-frame counter; each burst carries the number of its own frame.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_frm_cnt  <= 16'd0;
            r_frm_hold <= 16'd0;
        end else if (w_en_rise) begin
            r_frm_cnt  <= 16'd0;
        end else if (w_accept) begin
            r_frm_hold <= r_frm_cnt;
            r_frm_cnt  <= r_frm_cnt + 16'd1;
        end
    end

    assign w_word = test_en ? {8'hAD, 5'd0, r_chan, r_frm_hold} : r_hold[r_chan];
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;
    assign w_word           = r_hold[r_chan];
`endif

    assign wb_cyc_o = (r_state == S_WRITE);
    assign wb_stb_o = (r_state == S_WRITE);
    assign wb_we_o  = (r_state == S_WRITE);
    assign wb_sel_o = (r_state == S_WRITE) ? 4'hF : 4'h0;
    // r_live keeps address and data at zero while in reset.
    assign wb_adr_o = r_live ? w_adr_sum : 32'd0;
    assign wb_dat_o = r_live ? w_word : 32'd0;
    assign busy     = w_busy;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign wr_ptr   = r_wr_ptr;

endmodule

// File: tb/tb_adc_capture_wb.sv
// tb/tb_adc_capture_wb.sv - scoreboard testbench for adc_capture_wb
module tb_adc_capture_wb;

    localparam int          NCH    = 4;
    localparam int          ADDR_W = 4;
    localparam logic [31:0] BASE   = 32'h0;

    logic           wb_clk_i = 1'b0;
    logic           reset_n  = 1'b1;
    logic           adc_clk  = 1'b0;
    logic [NCH-1:0] adc_dat  = '0;
    logic           enable   = 1'b0;
    logic           mode     = 1'b1;
    logic           clr_ovf  = 1'b0;
    logic           test_en  = 1'b0;
    logic           wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]     wb_sel_o;
    logic [31:0]    wb_adr_o, wb_dat_o;
    logic           wb_ack_i = 1'b0;
    logic           busy, done, overflow;
    logic [ADDR_W-1:0] wr_ptr;

    int checks   = 0;
    int failures = 0;
    int ack_delay = 0;
    int ack_wait  = 0;
    int wr_cnt    = 0;
    int exp_ptr   = 0;
    bit exp_full  = 0;
    logic [63:0] exp_q [$];

    adc_capture_wb #(.NCH(NCH), .ADDR_W(ADDR_W), .BASE_ADR(BASE)) dut (
        .wb_clk_i(wb_clk_i), .reset_n(reset_n), .adc_clk(adc_clk), .adc_dat(adc_dat),
        .enable(enable), .mode(mode), .clr_ovf(clr_ovf), .test_en(test_en),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i),
        .busy(busy), .done(done), .overflow(overflow), .wr_ptr(wr_ptr)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus slave: acks after ack_delay cycles and pops the scoreboard on each write.
    always @(negedge wb_clk_i) begin
        logic [63:0] e;
        if (wb_ack_i) begin
            wb_ack_i = 1'b0;
        end else if (reset_n && wb_cyc_o && wb_stb_o) begin
            if (ack_wait < ack_delay) begin
                ack_wait++;
            end else begin
                ack_wait = 0;
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got adr=%h dat=%h expected none", wb_adr_o, wb_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_adr_o, wb_dat_o} !== e)
                        begin failures++; $display("FAIL write_data got adr=%h dat=%h expected adr=%h dat=%h", wb_adr_o, wb_dat_o, e[63:32], e[31:0]); end
                end
                checks++;
                if ({wb_we_o, wb_sel_o, busy} !== 6'b111111)
                    begin failures++; $display("FAIL write_ctrl got we/sel/busy=%b expected 111111", {wb_we_o, wb_sel_o, busy}); end
                wb_ack_i = 1'b1;
            end
        end
    end

    task automatic push_frame(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int c = 0; c < NCH; c++) begin
            if (exp_full) return;
            exp_q.push_back({BASE + 32'(exp_ptr * 4), d[c]});
            exp_ptr = (exp_ptr + 1) % (1 << ADDR_W);
            if (!mode && exp_ptr == 0) exp_full = 1;
        end
    endtask

    task automatic send_frame(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        for (int i = 0; i < 32; i++) begin
            @(negedge wb_clk_i);
            adc_clk = 1'b0;
            adc_dat = {d3[i], d2[i], d1[i], d0[i]};
            @(negedge wb_clk_i);
            @(negedge wb_clk_i);
            adc_clk = 1'b1;
            @(negedge wb_clk_i);
        end
        @(negedge wb_clk_i);
        adc_clk = 1'b0;
    endtask

    task automatic frame(input bit expect_write);
        logic [31:0] d [4];
        for (int c = 0; c < 4; c++) d[c] = $urandom;
        if (expect_write) push_frame(d[0], d[1], d[2], d[3]);
        send_frame(d[0], d[1], d[2], d[3]);
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        repeat (4) @(negedge wb_clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL write_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_capture(input logic m);
        @(negedge wb_clk_i);
        enable = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        mode = m;
        enable = 1'b1;
        exp_ptr = 0;
        exp_full = 0;
        @(negedge wb_clk_i);
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0)
            begin failures++; $display("FAIL reset_bus got %b expected 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
        checks++;
        if ({wb_adr_o, wb_dat_o} !== 64'd0)
            begin failures++; $display("FAIL reset_adr_dat got %h expected 0", {wb_adr_o, wb_dat_o}); end
        checks++;
        if ({busy, done, overflow, wr_ptr} !== 7'd0)
            begin failures++; $display("FAIL reset_status got %b expected 0", {busy, done, overflow, wr_ptr}); end
        reset_n = 1'b1;
        repeat (2) @(negedge wb_clk_i);
    endtask

    task automatic test_ring_first();
        start_capture(1'b1);
        push_frame(32'hABCDEF01, 32'h12345678, 32'h0F0F0F0F, 32'h80000001);
        send_frame(32'hABCDEF01, 32'h12345678, 32'h0F0F0F0F, 32'h80000001);
        wait_empty(200);
        checks++;
        if (wr_ptr !== 4'd4) begin failures++; $display("FAIL ring_first_ptr got %0d expected 4", wr_ptr); end
    endtask

    task automatic test_ring_wrap();
        for (int f = 0; f < 4; f++) frame(1'b1);
        wait_empty(200);
        checks++;
        if (wr_ptr !== 4'd4) begin failures++; $display("FAIL ring_wrap_ptr got %0d expected 4", wr_ptr); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL ring_done got %b expected 0", done); end
    endtask

    task automatic test_oneshot();
        int n;
        start_capture(1'b0);
        for (int f = 0; f < 4; f++) frame(1'b1);
        wait_empty(200);
        checks++;
        if ({done, busy, wr_ptr} !== 6'b100000)
            begin failures++; $display("FAIL oneshot_full got done/busy/ptr=%b expected 100000", {done, busy, wr_ptr}); end
        n = wr_cnt;
        frame(1'b0);
        repeat (20) @(negedge wb_clk_i);
        checks++;
        if (wr_cnt !== n) begin failures++; $display("FAIL oneshot_discard got %0d writes expected %0d", wr_cnt, n); end
        checks++;
        if ({overflow, done} !== 2'b01)
            begin failures++; $display("FAIL oneshot_flags got ovf/done=%b expected 01", {overflow, done}); end
    endtask

    task automatic test_overflow();
        start_capture(1'b1);
        ack_delay = 40;
        frame(1'b1);
        frame(1'b0);
        repeat (6) @(negedge wb_clk_i);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got %b expected 1", overflow); end
        wait_empty(400);
        ack_delay = 0;
        clr_ovf = 1'b1;
        @(negedge wb_clk_i);
        clr_ovf = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got %b expected 0", overflow); end
        checks++;
        if (wr_ptr !== 4'd4) begin failures++; $display("FAIL overflow_ptr got %0d expected 4", wr_ptr); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start_capture(1'b1);
        ack_delay = 20;
        frame(1'b0);
        while (!wb_stb_o && n < 50) begin
            @(negedge wb_clk_i);
            n++;
        end
        checks++;
        if (wb_stb_o !== 1'b1) begin failures++; $display("FAIL reset_mid_stb got %b expected 1", wb_stb_o); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy, done, overflow, wr_ptr} !== 14'd0)
            begin failures++; $display("FAIL reset_mid_outputs got %b expected 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy, done, overflow, wr_ptr}); end
        checks++;
        if ({wb_adr_o, wb_dat_o} !== 64'd0)
            begin failures++; $display("FAIL reset_mid_adr_dat got %h expected 0", {wb_adr_o, wb_dat_o}); end
        ack_delay = 0;
        ack_wait = 0;
        exp_q.delete();
        exp_ptr = 0;
        exp_full = 0;
        repeat (3) @(negedge wb_clk_i);
        reset_n = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        frame(1'b1);
        wait_empty(200);
    endtask

`ifdef ADC_CAPTURE_TESTPAT_EN
    task automatic test_testpat();
        start_capture(1'b1);
        test_en = 1'b1;
        push_frame(32'hAD000000, 32'hAD010000, 32'hAD020000, 32'hAD030000);
        send_frame($urandom, $urandom, $urandom, $urandom);
        push_frame(32'hAD000001, 32'hAD010001, 32'hAD020001, 32'hAD030001);
        send_frame($urandom, $urandom, $urandom, $urandom);
        wait_empty(200);
        test_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ring_first();
        test_ring_wrap();
        test_oneshot();
        test_overflow();
        test_reset_mid();
`ifdef ADC_CAPTURE_TESTPAT_EN
        test_testpat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_capture_wb.md
ADC_CAPTURE_WB -- requirements
Module: adc_capture_wb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NCH, 4: number of serial ADC channels, 1..8.
- ADDR_W, 11: word-address width; capture depth is 2^ADDR_W 32-bit words.
- BASE_ADR, 32'h0: byte base address of the capture buffer.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- wb_clk_i, in, 1: sole clock.
- reset_n, in, 1: asynchronous, active-low reset.
- adc_clk, in, 1: ADC bit clock; sampled as data, never used as a clock.
- adc_dat, in, NCH: one serial bitstream per channel.
- enable, in, 1: capture enable.
- mode, in, 1: 0 = one-shot, 1 = ring.
- clr_ovf, in, 1: one-cycle pulse that clears overflow.
- test_en, in, 1: selects the test pattern (see Configuration).
- wb_cyc_o, out, 1: Wishbone master cycle.
- wb_stb_o, out, 1: Wishbone strobe.
- wb_we_o, out, 1: Wishbone write enable.
- wb_sel_o, out, 4: Wishbone byte selects.
- wb_adr_o, out, 32: Wishbone byte address.
- wb_dat_o, out, 32: Wishbone write data.
- wb_ack_i, in, 1: Wishbone acknowledge.
- busy, out, 1: a burst is in progress.
- done, out, 1: one-shot buffer is full.
- overflow, out, 1: sticky frame-drop flag.
- wr_ptr, out, ADDR_W: next word index to be written.

Function
REQ-003 adc_clk and adc_dat SHALL pass through matched 2-FF synchronisers; a 0->1 transition on synchronised adc_clk is a "bit event".
REQ-004 Each bit event with enable=1 SHALL shift every channel's 32-bit register right, inserting the new bit at bit 31; the first bit of a frame ends in bit 0.
REQ-005 A 5-bit bit counter SHALL count bit events; the event that wraps it from 31 to 0 completes a frame and copies all NCH shift registers into holding registers in the same cycle.
REQ-006 One cycle after a frame completes, the burst FSM SHALL leave IDLE unless done=1.
REQ-007 FSM states and transitions SHALL be:
- IDLE: go to WRITE when a frame is pending.
- WRITE: hold wb_cyc_o=wb_stb_o=wb_we_o=1 and wb_sel_o=4'hF until wb_ack_i=1.
- NEXT: one cycle with cyc/stb low; increment the channel index and wr_ptr. Go to WRITE if channels remain, else to IDLE, or to FULL if one-shot and wr_ptr wrapped.
- FULL: stay until enable rises.
REQ-008 Channel writes SHALL be interleaved in order: frame f, channel c lands at word (f*NCH + c) mod 2^ADDR_W.
REQ-009 wb_adr_o SHALL equal BASE_ADR + {wr_ptr, 2'b00}, with the sum truncated to 32 bits.
REQ-010 wb_dat_o SHALL be the holding register of the current channel.
REQ-011 Ring mode: wr_ptr SHALL wrap from 2^ADDR_W-1 to 0 and capture SHALL continue.
REQ-012 One-shot mode: when wr_ptr wraps, done SHALL go to 1, the FSM SHALL go to FULL, and later frames SHALL be discarded without setting overflow.
REQ-013 A frame completing while busy=1 SHALL be discarded, and overflow SHALL be set; the holding registers SHALL stay unchanged.
REQ-014 If clr_ovf and a new overflow occur in the same cycle, overflow SHALL end that cycle at 1.
REQ-015 enable=0 SHALL halt shifting and zero the bit counter; an active burst SHALL complete.
REQ-016 An enable 0->1 edge SHALL clear wr_ptr, done and the channel index.
REQ-017 busy SHALL be 1 in WRITE and NEXT, and 0 otherwise.

Reset
REQ-018 While reset_n=0, all outputs SHALL be 0, including wb_sel_o=0, wb_adr_o=0 and wb_dat_o=0.
REQ-019 While reset_n=0, the FSM SHALL be in IDLE and all counters, shift, holding and synchroniser registers SHALL be 0.
REQ-020 Reset asserted mid-burst SHALL drop wb_cyc_o immediately; the partial burst SHALL NOT be resumed.

Configuration
REQ-021 Macro ADC_CAPTURE_TESTPAT_EN defined: when test_en=1, the word for channel c SHALL be {8'hAD, c[7:0], frame_count[15:0]}; frame_count is a 16-bit count of accepted frames that clears on an enable 0->1 edge.
REQ-022 Macro ADC_CAPTURE_TESTPAT_EN undefined: test_en SHALL be ignored, and no frame counter SHALL exist.

Verification
REQ-023 NCH=4, ADDR_W=4, ring mode, one ack per write 1 cycle after stb; channel 0 serial 0xABCDEF01 LSB first -> first write has adr=0x0 and dat=0xABCDEF01, and adr runs 0x0,0x4,0x8,0xC.
REQ-024 Ring mode, 5 frames with 4 channels -> 20 writes, wr_ptr wraps 15->0, and the last write has adr=0xC; done stays 0.
REQ-025 One-shot mode, same setup -> done=1 after the 16th ack; frame 5 causes no bus activity and overflow stays 0.
REQ-026 wb_ack_i withheld 40 cycles with adc_clk = wb_clk_i/4 -> next frame dropped and overflow=1; a clr_ovf pulse -> overflow=0.
REQ-027 reset_n pulled low while wb_stb_o=1 -> all outputs are 0 within the same cycle; after release, the next frame writes at BASE_ADR.
REQ-028 ADC_CAPTURE_TESTPAT_EN defined, test_en=1, NCH=2 -> the second frame writes 0xAD000001 then 0xAD010001.
